// File: rtl/sync_fifo_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_prog_if
// Description : Write/read handshake and status bundle for sync_fifo_prog.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_prog_if #(
    parameter int DATASIZE     = 8,
    parameter int ADDRESS_BITS = 4
);
    logic                    write_inc;
    logic [DATASIZE-1:0]     write_data;
    logic                    read_inc;
    logic                    err_clr;
    logic [DATASIZE-1:0]     read_data;
    logic                    write_full;
    logic                    rempty;
    logic                    almost_full;
    logic                    almost_empty;
    logic [ADDRESS_BITS:0]   fill_count;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output write_inc, write_data, read_inc, err_clr,
        input  read_data, write_full, rempty, almost_full, almost_empty,
               fill_count, overflow, underflow
    );

    modport slave (
        input  write_inc, write_data, read_inc, err_clr,
        output read_data, write_full, rempty, almost_full, almost_empty,
               fill_count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_prog
// Description : Single-clock FIFO with programmable almost-full/empty flags,
//               registered or first-word-fall-through read, and optional
//               sticky overflow/underflow flags (macro SYNC_FIFO_ERR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
    parameter int DATASIZE        = 8,
    parameter int ADDRESS_BITS    = 4,
    parameter int ALMOST_FULL_TH  = (2**ADDRESS_BITS) - 2,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter int FWFT            = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sync_fifo_prog_if.slave   bus
);
    localparam int                      c_depth     = 2**ADDRESS_BITS;
    localparam logic [ADDRESS_BITS:0]   c_depth_cnt = (ADDRESS_BITS+1)'(c_depth);
    localparam logic [ADDRESS_BITS:0]   c_af_th     = (ADDRESS_BITS+1)'(ALMOST_FULL_TH);
    localparam logic [ADDRESS_BITS:0]   c_ae_th     = (ADDRESS_BITS+1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDRESS_BITS:0]   c_cnt_one   = (ADDRESS_BITS+1)'(1);
    localparam logic [ADDRESS_BITS-1:0] c_ptr_one   = ADDRESS_BITS'(1);

    logic [ADDRESS_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_BITS:0]   fill_count_q, fill_count_d;
    logic [DATASIZE-1:0]     mem_q [c_depth];

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_rd_accept;

    // All status is decoded from the registered count, never from the requests.
    assign w_full      = (fill_count_q == c_depth_cnt);
    assign w_empty     = (fill_count_q == '0);
    assign w_wr_accept = bus.write_inc & ~w_full;
    assign w_rd_accept = bus.read_inc  & ~w_empty;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_count_d = fill_count_q;
        if (w_wr_accept) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_rd_accept) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({w_wr_accept, w_rd_accept})
            2'b10:   fill_count_d = fill_count_q + c_cnt_one;
            2'b01:   fill_count_d = fill_count_q - c_cnt_one;
            default: fill_count_d = fill_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_count_q <= fill_count_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_accept && !rst) begin
            mem_q[wr_ptr_q] <= bus.write_data;
        end
    end

    assign bus.write_full   = w_full;
    assign bus.rempty       = w_empty;
    assign bus.almost_full  = (fill_count_q >= c_af_th);
    assign bus.almost_empty = (fill_count_q <= c_ae_th);
    assign bus.fill_count   = fill_count_q;

    generate
        if (FWFT != 0) begin : g_fwft
            // Masked while empty so the output reads 0 out of reset.
            assign bus.read_data = w_empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_registered
            logic [DATASIZE-1:0] read_data_q, read_data_d;

            always_comb begin
                read_data_d = read_data_q;
                if (w_rd_accept) begin
                    read_data_d = mem_q[rd_ptr_q];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    read_data_q <= '0;
                end else begin
                    read_data_q <= read_data_d;
                end
            end

            assign bus.read_data = read_data_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A clear in the same cycle as a new error wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (bus.write_inc && w_full) begin
                overflow_d = 1'b1;
            end
            if (bus.read_inc && w_empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = bus.err_clr;
    assign bus.overflow     = 1'b0;
    assign bus.underflow    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_prog
// Description : Directed self-checking bench for sync_fifo_prog (FWFT=0 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_prog;
`ifdef SYNC_FIFO_ERR_EN
    localparam logic c_err_en = 1'b1;
`else
    localparam logic c_err_en = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sync_fifo_prog_if #(.DATASIZE(8), .ADDRESS_BITS(4)) f0 ();
    sync_fifo_prog_if #(.DATASIZE(8), .ADDRESS_BITS(4)) f1 ();

    sync_fifo_prog #(
        .DATASIZE(8), .ADDRESS_BITS(4), .ALMOST_FULL_TH(14),
        .ALMOST_EMPTY_TH(2), .FWFT(0)
    ) dut_reg (
        .clk (clk),
        .rst (rst),
        .bus (f0)
    );

    sync_fifo_prog #(
        .DATASIZE(8), .ADDRESS_BITS(4), .ALMOST_FULL_TH(14),
        .ALMOST_EMPTY_TH(2), .FWFT(1)
    ) dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (f1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        f0.write_inc = 1'b0; f0.read_inc = 1'b0; f0.err_clr = 1'b0; f0.write_data = 8'h00;
        f1.write_inc = 1'b0; f1.read_inc = 1'b0; f1.err_clr = 1'b0; f1.write_data = 8'h00;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [18:0] obs;
        apply_reset();
        obs = {f0.fill_count, f0.rempty, f0.almost_empty, f0.write_full, f0.almost_full,
               f0.read_data, f0.overflow, f0.underflow};
        checks++;
        if (obs !== {5'd0, 4'b1100, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, {5'd0, 4'b1100, 8'h00, 2'b00});
        end
        checks++;
        if ({f1.rempty, f1.read_data, f1.fill_count} !== {1'b1, 8'h00, 5'd0}) begin
            errors++;
            $display("FAIL reset_fwft: got %h expected %h",
                     {f1.rempty, f1.read_data, f1.fill_count}, {1'b1, 8'h00, 5'd0});
        end
    endtask

    task automatic test_fill_drain;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            f0.write_inc = 1'b1; f0.write_data = 8'(i);
            tick();
            checks++;
            if ({f0.fill_count, f0.write_full} !== {5'(i + 1), (i == 15)}) begin
                errors++;
                $display("FAIL fill_write%0d: got cnt=%0d full=%b expected cnt=%0d full=%b",
                         i, f0.fill_count, f0.write_full, i + 1, (i == 15));
            end
        end
        f0.write_inc = 1'b0;
        for (int i = 0; i < 16; i++) begin
            f0.read_inc = 1'b1;
            tick();
            checks++;
            if ({f0.read_data, f0.rempty} !== {8'(i), (i == 15)}) begin
                errors++;
                $display("FAIL drain_read%0d: got data=%h empty=%b expected data=%h empty=%b",
                         i, f0.read_data, f0.rempty, 8'(i), (i == 15));
            end
        end
        f0.read_inc = 1'b0;
    endtask

    task automatic test_thresholds;
        apply_reset();
        for (int k = 1; k <= 15; k++) begin
            f0.write_inc = 1'b1; f0.write_data = 8'(k);
            tick();
            checks++;
            if ({f0.fill_count, f0.almost_empty, f0.almost_full} !== {5'(k), (k <= 2), (k >= 14)}) begin
                errors++;
                $display("FAIL threshold_k%0d: got cnt=%0d ae=%b af=%b expected cnt=%0d ae=%b af=%b",
                         k, f0.fill_count, f0.almost_empty, f0.almost_full, k, (k <= 2), (k >= 14));
            end
        end
        f0.write_inc = 1'b0;
        f0.read_inc  = 1'b1;
        tick();
        tick();
        f0.read_inc  = 1'b0;
        checks++;
        if ({f0.fill_count, f0.almost_full} !== {5'd13, 1'b0}) begin
            errors++;
            $display("FAIL threshold_af_fall: got cnt=%0d af=%b expected cnt=13 af=0",
                     f0.fill_count, f0.almost_full);
        end
    endtask

    task automatic test_full_simultaneous;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            f0.write_inc = 1'b1; f0.write_data = 8'(i);
            tick();
        end
        f0.write_data = 8'hAA; f0.read_inc = 1'b1;
        tick();
        f0.write_inc = 1'b0;
        checks++;
        if ({f0.read_data, f0.fill_count, f0.write_full, f0.overflow} !==
            {8'h00, 5'd15, 1'b0, c_err_en}) begin
            errors++;
            $display("FAIL full_simul: got data=%h cnt=%0d full=%b ovf=%b expected data=00 cnt=15 full=0 ovf=%b",
                     f0.read_data, f0.fill_count, f0.write_full, f0.overflow, c_err_en);
        end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++;
            if (f0.read_data !== 8'(i)) begin
                errors++;
                $display("FAIL full_drain%0d: got %h expected %h", i, f0.read_data, 8'(i));
            end
        end
        // FIFO now empty; this read is rejected and raises underflow.
        tick();
        f0.read_inc = 1'b0;
        checks++;
        if ({f0.rempty, f0.fill_count, f0.read_data, f0.overflow, f0.underflow} !==
            {1'b1, 5'd0, 8'h0F, c_err_en, c_err_en}) begin
            errors++;
            $display("FAIL underflow_set: got empty=%b cnt=%0d data=%h ovf=%b udf=%b expected 1 0 0f %b %b",
                     f0.rempty, f0.fill_count, f0.read_data, f0.overflow, f0.underflow, c_err_en, c_err_en);
        end
        f0.err_clr = 1'b1; f0.read_inc = 1'b1;
        tick();
        f0.err_clr = 1'b0; f0.read_inc = 1'b0;
        checks++;
        if ({f0.overflow, f0.underflow} !== 2'b00) begin
            errors++;
            $display("FAIL err_clr_priority: got ovf=%b udf=%b expected 0 0", f0.overflow, f0.underflow);
        end
    endtask

    task automatic test_empty_simultaneous;
        apply_reset();
        f0.write_inc = 1'b1; f0.write_data = 8'h77; f0.read_inc = 1'b1;
        tick();
        f0.write_inc = 1'b0; f0.read_inc = 1'b0;
        checks++;
        if ({f0.fill_count, f0.rempty, f0.read_data, f0.underflow} !== {5'd1, 1'b0, 8'h00, c_err_en}) begin
            errors++;
            $display("FAIL empty_simul: got cnt=%0d empty=%b data=%h udf=%b expected 1 0 00 %b",
                     f0.fill_count, f0.rempty, f0.read_data, f0.underflow, c_err_en);
        end
        f0.read_inc = 1'b1;
        tick();
        f0.read_inc = 1'b0;
        checks++;
        if ({f0.read_data, f0.rempty} !== {8'h77, 1'b1}) begin
            errors++;
            $display("FAIL empty_simul_pop: got data=%h empty=%b expected 77 1", f0.read_data, f0.rempty);
        end
    endtask

    task automatic test_back_to_back_wrap;
        apply_reset();
        f0.write_inc = 1'b1; f0.write_data = 8'h00;
        tick();
        for (int i = 0; i < 40; i++) begin
            f0.write_data = 8'(i + 1); f0.read_inc = 1'b1;
            tick();
            checks++;
            if ({f0.read_data, f0.fill_count} !== {8'(i), 5'd1}) begin
                errors++;
                $display("FAIL wrap_pair%0d: got data=%h cnt=%0d expected data=%h cnt=1",
                         i, f0.read_data, f0.fill_count, 8'(i));
            end
        end
        f0.write_inc = 1'b0; f0.read_inc = 1'b0;
    endtask

    task automatic test_fwft;
        apply_reset();
        f1.write_inc = 1'b1; f1.write_data = 8'h5A;
        tick();
        f1.write_inc = 1'b0;
        checks++;
        if ({f1.read_data, f1.rempty} !== {8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL fwft_fall: got data=%h empty=%b expected 5a 0", f1.read_data, f1.rempty);
        end
        f1.write_inc = 1'b1; f1.write_data = 8'hC3;
        tick();
        f1.write_inc = 1'b0;
        checks++;
        if ({f1.read_data, f1.fill_count} !== {8'h5A, 5'd2}) begin
            errors++;
            $display("FAIL fwft_hold: got data=%h cnt=%0d expected 5a 2", f1.read_data, f1.fill_count);
        end
        f1.read_inc = 1'b1;
        tick();
        checks++;
        if (f1.read_data !== 8'hC3) begin
            errors++;
            $display("FAIL fwft_next: got %h expected c3", f1.read_data);
        end
        tick();
        f1.read_inc = 1'b0;
        checks++;
        if ({f1.rempty, f1.fill_count} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL fwft_empty: got empty=%b cnt=%0d expected 1 0", f1.rempty, f1.fill_count);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            f0.write_inc = 1'b1; f0.write_data = 8'(8'h30 + i);
            tick();
        end
        f0.write_inc = 1'b0; f0.read_inc = 1'b1;
        tick();
        f0.read_inc = 1'b0;
        checks++;
        if ({f0.fill_count, f0.read_data} !== {5'd9, 8'h30}) begin
            errors++;
            $display("FAIL rst_mid_pre: got cnt=%0d data=%h expected 9 30", f0.fill_count, f0.read_data);
        end
        rst = 1'b1; f0.write_inc = 1'b1; f0.write_data = 8'hEE;
        tick();
        rst = 1'b0; f0.write_inc = 1'b0;
        checks++;
        if ({f0.fill_count, f0.rempty, f0.read_data, f0.overflow, f0.underflow} !==
            {5'd0, 1'b1, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL rst_mid: got cnt=%0d empty=%b data=%h ovf=%b udf=%b expected 0 1 00 0 0",
                     f0.fill_count, f0.rempty, f0.read_data, f0.overflow, f0.underflow);
        end
        tick();
        checks++;
        if ({f0.fill_count, f0.rempty} !== {5'd0, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_after: got cnt=%0d empty=%b expected 0 1", f0.fill_count, f0.rempty);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_fill_drain();
        test_thresholds();
        test_full_simultaneous();
        test_empty_simultaneous();
        test_back_to_back_wrap();
        test_fwft();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
